// File: rtl/rf8_burst_slave.sv
// Eight-word, 32-bit register file served over a simple request/burst bus.
// Bursts auto-increment the word pointer with modulo-8 wrap; reads stream one beat per cycle.
module rf8_burst_slave (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s_req,
   input  logic        s_wr,
   input  logic [2:0]  s_addr,
   input  logic [2:0]  s_len,
   input  logic        s_valid,
   input  logic [31:0] s_din,
   output logic        s_ready,
   output logic [31:0] s_dout,
   output logic        s_rvalid,
   output logic        s_busy,
   output logic        s_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e      state_q;
   logic [2:0]  ptr_q;
   logic [2:0]  cnt_q;
   logic [2:0]  ptr_d;
   logic [31:0] regs_q [8];
   logic [7:0]  wrSel;
   logic [31:0] rdData;
   logic [31:0] dout_q;
   logic        rvalid_q;

   // The 3-bit add wraps naturally, giving the modulo-8 burst addressing.
   assign ptr_d  = ptr_q + 3'd1;
   assign rdData = regs_q[ptr_q];

   always_comb begin
      wrSel = '0;
      if (state_q == WRITE && s_valid) begin
         wrSel[ptr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wrSel[i]) begin
               regs_q[i] <= s_din;
            end
         end
      end
   end

   // cnt_q holds beats remaining minus one, so the last beat is the one seen with cnt_q == 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_req) begin
                  ptr_q   <= s_addr;
                  cnt_q   <= s_len;
                  state_q <= s_wr ? WRITE : READ;
               end
            end
            WRITE: begin
               if (s_valid) begin
                  ptr_q <= ptr_d;
                  if (cnt_q == 3'd0) begin
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q - 3'd1;
                  end
               end
            end
            READ: begin
               dout_q   <= rdData;
               rvalid_q <= 1'b1;
               ptr_q    <= ptr_d;
               if (cnt_q == 3'd0) begin
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE: begin
               rvalid_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_ready  = (state_q == WRITE);
   assign s_busy   = (state_q != IDLE);
   assign s_done   = (state_q == DONE);
   assign s_dout   = dout_q;
   assign s_rvalid = rvalid_q;

endmodule

// File: tb/tb_rf8_burst_slave.sv
// Directed bench for rf8_burst_slave: single beats, wrap bursts, write stalls,
// ignored requests while busy, and asynchronous reset mid-burst.
module tb_rf8_burst_slave;

   logic        clk;
   logic        reset_n;
   logic        s_req;
   logic        s_wr;
   logic [2:0]  s_addr;
   logic [2:0]  s_len;
   logic        s_valid;
   logic [31:0] s_din;
   logic        s_ready;
   logic [31:0] s_dout;
   logic        s_rvalid;
   logic        s_busy;
   logic        s_done;

   int          assertCount;
   int          failCount;
   logic [31:0] writeWords [8];
   logic [31:0] expWords [8];

   rf8_burst_slave dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_req    (s_req),
      .s_wr     (s_wr),
      .s_addr   (s_addr),
      .s_len    (s_len),
      .s_valid  (s_valid),
      .s_din    (s_din),
      .s_ready  (s_ready),
      .s_dout   (s_dout),
      .s_rvalid (s_rvalid),
      .s_busy   (s_busy),
      .s_done   (s_done)
   );

   // 10 ns clock; every check happens 1 ns after a rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic wr, input logic [2:0] addr,
                                input logic [2:0] len, input logic valid, input logic [31:0] din);
      s_req   = req;
      s_wr    = wr;
      s_addr  = addr;
      s_len   = len;
      s_valid = valid;
      s_din   = din;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Flags are packed as {s_ready, s_busy, s_done, s_rvalid}.
   task automatic checkFlags(input string tag, input logic [3:0] exp);
      checkOutput(tag, {28'd0, s_ready, s_busy, s_done, s_rvalid}, {28'd0, exp});
   endtask

   // Issues the request in the current cycle and ends in the first idle cycle after DONE.
   task automatic writeBurst(input logic [2:0] addr, input logic [2:0] len);
      applyStimulus(1'b1, 1'b1, addr, len, 1'b0, 32'd0);
      tick();
      for (int k = 0; k <= int'(len); k++) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, writeWords[k]);
         checkFlags($sformatf("wr beat %0d flags", k), 4'b1100);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);
      checkFlags("wr done flags", 4'b0110);
      tick();
      checkFlags("wr idle flags", 4'b0000);
   endtask

   task automatic readBurst(input logic [2:0] addr, input logic [2:0] len);
      applyStimulus(1'b1, 1'b0, addr, len, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);
      checkFlags("rd first cycle flags", 4'b0100);
      for (int k = 0; k <= int'(len); k++) begin
         tick();
         checkOutput($sformatf("rd beat %0d data", k), s_dout, expWords[k]);
         checkFlags($sformatf("rd beat %0d flags", k), (k == int'(len)) ? 4'b0111 : 4'b0101);
      end
      tick();
      checkFlags("rd idle flags", 4'b0000);
   endtask

   initial begin
      logic        stallValid [5];
      logic [31:0] stallData [5];

      assertCount = 0;
      failCount   = 0;
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);

      $display("[TB] power-up reset");
      reset_n = 1'b0;
      #3;
      checkFlags("reset flags", 4'b0000);
      checkOutput("reset dout", s_dout, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) expWords[i] = 32'd0;
      readBurst(3'd0, 3'd7);

      $display("[TB] single-beat write and read");
      writeWords[0] = 32'hDEADBEEF;
      writeBurst(3'd3, 3'd0);
      expWords[0] = 32'hDEADBEEF;
      readBurst(3'd3, 3'd0);

      $display("[TB] wrap burst");
      for (int i = 0; i < 8; i++) writeWords[i] = 32'h100 + 32'(i);
      writeBurst(3'd5, 3'd7);
      expWords[0] = 32'h103; expWords[1] = 32'h104; expWords[2] = 32'h105; expWords[3] = 32'h106;
      expWords[4] = 32'h107; expWords[5] = 32'h100; expWords[6] = 32'h101; expWords[7] = 32'h102;
      readBurst(3'd0, 3'd7);

      $display("[TB] write with stalls");
      stallValid[0] = 1'b1; stallValid[1] = 1'b0; stallValid[2] = 1'b0;
      stallValid[3] = 1'b1; stallValid[4] = 1'b1;
      stallData[0] = 32'hA0; stallData[1] = 32'hBAD0; stallData[2] = 32'hBAD1;
      stallData[3] = 32'hA1; stallData[4] = 32'hA2;
      applyStimulus(1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 32'd0);
      tick();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, stallValid[k], stallData[k]);
         checkFlags($sformatf("stall cycle %0d flags", k + 1), 4'b1100);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);
      checkFlags("stall done at T+6", 4'b0110);
      tick();
      checkFlags("stall idle at T+7", 4'b0000);
      expWords[0] = 32'hA0; expWords[1] = 32'hA1; expWords[2] = 32'hA2; expWords[3] = 32'h106;
      readBurst(3'd0, 3'd3);

      $display("[TB] request ignored while busy");
      applyStimulus(1'b1, 1'b0, 3'd4, 3'd3, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 3'd7, 3'd0, 1'b1, 32'hFFFFFFFF);
      checkFlags("busy req cycle flags", 4'b0100);
      expWords[0] = 32'h107; expWords[1] = 32'h100; expWords[2] = 32'h101; expWords[3] = 32'h102;
      for (int k = 0; k < 4; k++) begin
         tick();
         applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);
         checkOutput($sformatf("busy rd beat %0d data", k), s_dout, expWords[k]);
         checkFlags($sformatf("busy rd beat %0d flags", k), (k == 3) ? 4'b0111 : 4'b0101);
      end
      tick();
      checkFlags("busy rd idle flags", 4'b0000);
      expWords[0] = 32'h102;
      readBurst(3'd7, 3'd0);

      $display("[TB] reset during write burst");
      applyStimulus(1'b1, 1'b1, 3'd0, 3'd7, 1'b0, 32'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h5500 + 32'(k));
         if (k < 2) tick();
      end
      #2;
      reset_n = 1'b0;
      #1;
      checkFlags("mid reset flags", 4'b0000);
      checkOutput("mid reset dout", s_dout, 32'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) expWords[i] = 32'd0;
      readBurst(3'd0, 3'd7);
      readBurst(3'd5, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
